// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, serializer state type and element index helpers
package mat_pkg;

    localparam int MAT_ROWS    = 5;
    localparam int MAT_COLS    = 3;
    localparam int MAT_EW      = 15;
    localparam int MAT_ELEMS   = 15;
    localparam int MUL_LATENCY = 2;
    localparam int C_W         = MAT_ELEMS * MAT_EW;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_e;

    // Row-major walk: element k sits at row k/MAT_COLS, column k%MAT_COLS.
    function automatic logic [2:0] elem_row_of(input logic [3:0] k);
        return 3'(int'(k) / MAT_COLS);
    endfunction

    function automatic logic [1:0] elem_col_of(input logic [3:0] k);
        return 2'(int'(k) % MAT_COLS);
    endfunction

endpackage

// File: rtl/mat_result_streamer_if.sv
// rtl/mat_result_streamer_if.sv - element stream interface (valid/ready with row/col tags)
// master: drives elem_data/elem_row/elem_col/elem_last/elem_valid, samples elem_ready
// slave : samples the element fields, drives elem_ready
interface mat_result_streamer_if
    import mat_pkg::*;
#(
    parameter int EW = MAT_EW
);
    logic [EW-1:0] elem_data;
    logic [2:0]    elem_row;
    logic [1:0]    elem_col;
    logic          elem_last;
    logic          elem_valid;
    logic          elem_ready;

    modport master (
        output elem_data, elem_row, elem_col, elem_last, elem_valid,
        input  elem_ready
    );

    modport slave (
        input  elem_data, elem_row, elem_col, elem_last, elem_valid,
        output elem_ready
    );
endinterface

// File: rtl/mat_word_fifo.sv
// rtl/mat_word_fifo.sv - DEPTH x W synchronous FIFO for captured product words
// clk/rst   : clock, synchronous active-high reset
// push/push_data : write request; accepted when not full, or when full with a same-edge pop
// pop/pop_data   : read request; pop_data shows the head word combinationally
// full/empty/count : occupancy status from registered state
module mat_word_fifo
    import mat_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = C_W,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok  = pop && (count_q != '0);
        // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
        push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = (wr_q == LAST_IDX) ? '0 : wr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_d = (rd_q == LAST_IDX) ? '0 : rd_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
endmodule

// File: rtl/mat_result_streamer.sv
// rtl/mat_result_streamer.sv - issue credit tracking, product capture and element serializer
// clk/rst     : clock, synchronous active-high reset
// issue       : multiplier started this cycle (honoured only with issue_ready)
// issue_ready : a buffer slot is reserved-free for one more product
// c_in        : packed 5x3 product, row-major, element [0][0] in the top bits
// elem        : element stream (master side of mat_result_streamer_if)
// overflow    : sticky, a capture found the buffer full
// busy        : tokens in flight, words buffered, or serializer loaded
module mat_result_streamer
    import mat_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY,
    parameter int DEPTH   = 2,
    parameter int EW      = MAT_EW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    output logic                    issue_ready,
    input  logic [MAT_ELEMS*EW-1:0] c_in,
    mat_result_streamer_if.master   elem,
    output logic                    overflow,
    output logic                    busy
);
    localparam int WW = MAT_ELEMS * EW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(LATENCY + 1);
    localparam int SW = ((CW > TW) ? CW : TW) + 1;
    localparam logic [3:0] K_LAST = 4'(MAT_ELEMS - 1);

    logic [LATENCY-1:0] token_q, token_d;
    logic [TW-1:0]      inflight;
    logic               credit_ok;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [WW-1:0]      fifo_rd_data;

    ser_state_e         state_q, state_d;
    logic [WW-1:0]      word_q, word_d;
    logic [3:0]         k_q, k_d;
    logic [EW-1:0]      data_q, data_d;
    logic [2:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic               last_q, last_d;
    logic               overflow_q, overflow_d;
    logic               xfer, at_last;

    // Every set bit of the token pipe is a product the multiplier still owes us.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + TW'(token_q[i]);
        end
    end

    // The serializer register is not counted: a word leaving the FIFO frees its credit.
    assign credit_ok   = (SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH);
    assign issue_ready = credit_ok;

    always_comb begin
        token_d    = '0;
        token_d[0] = issue && credit_ok;
        for (int i = 1; i < LATENCY; i++) begin
            token_d[i] = token_q[i-1];
        end
    end

    // c_in holds the product on the edge where its token leaves the last stage.
    assign fifo_push = token_q[LATENCY-1];

    assign xfer     = (state_q == SER_STREAM) && elem.elem_ready;
    assign at_last  = (k_q == K_LAST);
    // Pop when idle, or on the final transfer so the next word follows without a bubble.
    assign fifo_pop = !fifo_empty && ((state_q == SER_IDLE) || (xfer && at_last));

    mat_word_fifo #(
        .DEPTH (DEPTH),
        .W     (WW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (c_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        k_d     = k_q;
        case (state_q)
            SER_IDLE: begin
                if (fifo_pop) begin
                    state_d = SER_STREAM;
                    word_d  = fifo_rd_data;
                    k_d     = '0;
                end
            end
            SER_STREAM: begin
                if (xfer) begin
                    if (at_last) begin
                        k_d = '0;
                        if (fifo_pop) begin
                            word_d = fifo_rd_data;
                        end else begin
                            state_d = SER_IDLE;
                        end
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Output fields are registered from the next word/index so they hold through stalls.
        data_d = word_d[WW-1-EW*int'(k_d) -: EW];
        row_d  = elem_row_of(k_d);
        col_d  = elem_col_of(k_d);
        last_d = (state_d == SER_STREAM) && (k_d == K_LAST);

        overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_q    <= '0;
            state_q    <= SER_IDLE;
            word_q     <= '0;
            k_q        <= '0;
            data_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            token_q    <= token_d;
            state_q    <= state_d;
            word_q     <= word_d;
            k_q        <= k_d;
            data_q     <= data_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign elem.elem_data  = data_q;
    assign elem.elem_row   = row_q;
    assign elem.elem_col   = col_q;
    assign elem.elem_last  = last_q;
    assign elem.elem_valid = (state_q == SER_STREAM);

    assign overflow = overflow_q;
    assign busy     = (|token_q) || !fifo_empty || (state_q == SER_STREAM);
endmodule

// File: tb/tb_mat_result_streamer.sv
// tb/tb_mat_result_streamer.sv - self-checking bench for mat_result_streamer
module tb_mat_result_streamer;
    import mat_pkg::*;

    localparam int LAT = 2;
    localparam int DEP = 2;
    localparam int WW  = 225;

    typedef struct {
        logic [14:0] data;
        logic [2:0]  row;
        logic [1:0]  col;
        logic        last;
        int          edge_no;
    } xfer_t;

    logic          clk;
    logic          rst;
    logic          issue;
    logic          issue_ready;
    logic [WW-1:0] c_in;
    logic          overflow;
    logic          busy;

    mat_result_streamer_if sif ();

    mat_result_streamer #(
        .LATENCY (LAT),
        .DEPTH   (DEP),
        .EW      (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_ready (issue_ready),
        .c_in        (c_in),
        .elem        (sif),
        .overflow    (overflow),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [WW-1:0] sched [int];
    logic          ir_at [int];
    logic [WW-1:0] word_src [$];
    logic [WW-1:0] exp_words [$];
    int            acc_q [$];
    xfer_t         got_q [$];
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    xfer_t         prev_x;
    xfer_t         cur_x;
    logic [WW-1:0] mon_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [WW-1:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        return w[WW-1:0];
    endfunction

    // Element k of a product: row-major, element 0 in the most significant 15 bits.
    function automatic logic [20:0] exp_elem(input logic [WW-1:0] w, input int k);
        logic [14:0] d;
        d = 15'(w >> (15 * (14 - k)));
        return {d, 3'(k / 3), 2'(k % 3), (k == 14)};
    endfunction

    function automatic logic [20:0] pack_x(input xfer_t x);
        return {x.data, x.row, x.col, x.last};
    endfunction

    // c_in carries the scheduled product on its capture edge, noise otherwise.
    always @(negedge clk) begin
        if (sched.exists(cyc + 1)) c_in = sched[cyc + 1];
        else                      c_in = rand_word();
    end

    // Pre-edge sampler: records accepted issues, transfers and stall-rule violations.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_x.data    = sif.elem_data;
            cur_x.row     = sif.elem_row;
            cur_x.col     = sif.elem_col;
            cur_x.last    = sif.elem_last;
            cur_x.edge_no = cyc + 1;
            if (prev_stall && ((sif.elem_valid !== 1'b1) || (pack_x(cur_x) !== pack_x(prev_x))))
                stall_viol++;
            ir_at[cyc + 1] = issue_ready;
            if (issue && issue_ready) begin
                mon_w = (word_src.size() > 0) ? word_src.pop_front() : rand_word();
                sched[cyc + 1 + LAT] = mon_w;
                exp_words.push_back(mon_w);
                acc_q.push_back(cyc + 1);
            end
            if (sif.elem_valid && sif.elem_ready) got_q.push_back(cur_x);
            prev_stall = sif.elem_valid && !sif.elem_ready;
            prev_x     = cur_x;
        end
    end

    task automatic clear_model();
        sched.delete();
        ir_at.delete();
        word_src.delete();
        exp_words.delete();
        acc_q.delete();
        got_q.delete();
        stall_viol = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        issue = 1'b0;
        sif.elem_ready = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        rst = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue = 1'b1;
        sif.elem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            n_tests++;
            if ({issue_ready, sif.elem_valid, busy, overflow} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got {ir,valid,busy,ovf}=%b expected 1000", i,
                         {issue_ready, sif.elem_valid, busy, overflow});
            end
            n_tests++;
            if ({sif.elem_data, sif.elem_row, sif.elem_col, sif.elem_last} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_fields[%0d]: got %h expected 0", i,
                         {sif.elem_data, sif.elem_row, sif.elem_col, sif.elem_last});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        issue = 1'b0;
        clear_model();
        repeat (6) @(negedge clk);
        #4;
        n_tests++;
        if ({sif.elem_valid, busy, got_q.size() == 0} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_no_capture: got {valid,busy,none}=%b expected 001",
                     {sif.elem_valid, busy, got_q.size() == 0});
        end
    endtask

    task automatic test_single();
        logic [WW-1:0] fixed;
        int n;
        do_reset();
        fixed = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 3; j++)
                fixed[WW-1-15*(3*i+j) -: 15] = 15'(3*i + j + 1);
        word_src.push_back(fixed);
        @(negedge clk);
        issue = 1'b1;
        sif.elem_ready = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        wait_xfers(15, 40);
        repeat (4) @(negedge clk);
        n_tests++;
        if (acc_q.size() != 1 || got_q.size() != 15) begin
            n_fail++;
            $display("FAIL single_count: got issues=%0d xfers=%0d expected 1 and 15",
                     acc_q.size(), got_q.size());
        end
        n = (acc_q.size() > 0) ? acc_q[0] : 0;
        for (int k = 0; k < 15 && k < got_q.size(); k++) begin
            n_tests++;
            if (pack_x(got_q[k]) !== {15'(k + 1), 3'(k / 3), 2'(k % 3), (k == 14)} ||
                got_q[k].edge_no != n + 4 + k) begin
                n_fail++;
                $display("FAIL single_elem[%0d]: got %h at edge %0d expected %h at edge %0d", k,
                         pack_x(got_q[k]), got_q[k].edge_no,
                         {15'(k + 1), 3'(k / 3), 2'(k % 3), (k == 14)}, n + 4 + k);
            end
        end
        sif.elem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n0;
        logic bubble;
        do_reset();
        @(negedge clk);
        issue = 1'b1;
        for (int c = 0; c < 30 && acc_q.size() < 3; c++) @(negedge clk);
        issue = 1'b0;
        n0 = (acc_q.size() > 0) ? acc_q[0] : 0;
        n_tests++;
        if (acc_q.size() != 3 || acc_q[1] != n0 + 1 || acc_q[2] != n0 + 4) begin
            n_fail++;
            $display("FAIL b2b_accept: got %0d issues, edges +%0d +%0d expected 3 at +1 +4",
                     acc_q.size(), (acc_q.size() > 1) ? acc_q[1] - n0 : -1,
                     (acc_q.size() > 2) ? acc_q[2] - n0 : -1);
        end
        n_tests++;
        if ({ir_at.exists(n0 + 2) ? ir_at[n0 + 2] : 1'bx,
             ir_at.exists(n0 + 3) ? ir_at[n0 + 3] : 1'bx,
             ir_at.exists(n0 + 4) ? ir_at[n0 + 4] : 1'bx} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_credit: got issue_ready trace %b expected 001",
                     {ir_at[n0 + 2], ir_at[n0 + 3], ir_at[n0 + 4]});
        end
        repeat (6) @(negedge clk);
        sif.elem_ready = 1'b1;
        wait_xfers(45, 90);
        repeat (4) @(negedge clk);
        n_tests++;
        if (got_q.size() != 45) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 45", got_q.size());
        end
        bubble = 1'b0;
        for (int k = 0; k < 45 && k < got_q.size(); k++) begin
            if (got_q[k].edge_no != got_q[0].edge_no + k) bubble = 1'b1;
            n_tests++;
            if (pack_x(got_q[k]) !== exp_elem(exp_words[k / 15], k % 15)) begin
                n_fail++;
                $display("FAIL b2b_elem[%0d]: got %h expected %h", k, pack_x(got_q[k]),
                         exp_elem(exp_words[k / 15], k % 15));
            end
        end
        n_tests++;
        if (bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: got gap=%b expected 0", bubble);
        end
        sif.elem_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 400 && !(got_q.size() >= 60 && acc_q.size() >= 4); c++) begin
            @(negedge clk);
            issue = (acc_q.size() < 4);
            sif.elem_ready = (c % 4 == 0) || (c % 4 == 3);
        end
        issue = 1'b0;
        sif.elem_ready = 1'b1;
        repeat (8) @(negedge clk);
        n_tests++;
        if (got_q.size() != 60 || exp_words.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d xfers / %0d words expected 60 / 4",
                     got_q.size(), exp_words.size());
        end
        for (int k = 0; k < 60 && k < got_q.size(); k++) begin
            n_tests++;
            if (pack_x(got_q[k]) !== exp_elem(exp_words[k / 15], k % 15)) begin
                n_fail++;
                $display("FAIL bp_elem[%0d]: got %h expected %h", k, pack_x(got_q[k]),
                         exp_elem(exp_words[k / 15], k % 15));
            end
        end
        n_tests++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d stall violations expected 0", stall_viol);
        end
        sif.elem_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        force dut.credit_ok = 1'b1;
        issue = 1'b1;
        repeat (4) @(negedge clk);
        issue = 1'b0;
        release dut.credit_ok;
        repeat (6) @(negedge clk);
        #4;
        n_tests++;
        if (overflow !== 1'b1 || acc_q.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_set: got overflow=%b issues=%0d expected 1 and 4",
                     overflow, acc_q.size());
        end
        @(negedge clk);
        sif.elem_ready = 1'b1;
        wait_xfers(45, 90);
        repeat (10) @(negedge clk);
        n_tests++;
        if (got_q.size() != 45) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected 45", got_q.size());
        end
        for (int k = 0; k < 45 && k < got_q.size(); k++) begin
            n_tests++;
            if (pack_x(got_q[k]) !== exp_elem(exp_words[k / 15], k % 15)) begin
                n_fail++;
                $display("FAIL ovf_elem[%0d]: got %h expected %h", k, pack_x(got_q[k]),
                         exp_elem(exp_words[k / 15], k % 15));
            end
        end
        #4;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        do_reset();
        #4;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic sent2;
        do_reset();
        sent2 = 1'b0;
        @(negedge clk);
        issue = 1'b1;
        sif.elem_ready = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        for (int c = 0; c < 60 && got_q.size() < 7; c++) begin
            @(negedge clk);
            if (!sent2 && got_q.size() >= 5) begin
                issue = 1'b1;
                sent2 = 1'b1;
            end else begin
                issue = 1'b0;
            end
        end
        issue = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #4;
        n_tests++;
        if ({sif.elem_valid, issue_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_reset_state: got {valid,ir,busy}=%b expected 010",
                     {sif.elem_valid, issue_ready, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (got_q.size() != 7 || acc_q.size() != 2) begin
            n_fail++;
            $display("FAIL mid_reset_discard: got %0d xfers / %0d issues expected 7 / 2",
                     got_q.size(), acc_q.size());
        end
        for (int k = 0; k < 7 && k < got_q.size(); k++) begin
            n_tests++;
            if (pack_x(got_q[k]) !== exp_elem(exp_words[0], k)) begin
                n_fail++;
                $display("FAIL mid_elem[%0d]: got %h expected %h", k, pack_x(got_q[k]),
                         exp_elem(exp_words[0], k));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        issue = 1'b0;
        c_in = '0;
        sif.elem_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end
endmodule
